// File: rtl/column_mux.sv
// rtl/column_mux.sv - one-hot LED column multiplexer with dead time, slice tracking and timeout fault
module column_mux #(
    parameter int N_MUX       = 8,
    parameter int DEAD_CYCLES = 4,
    parameter int TIMEOUT     = 2048,
    parameter int N_SLICES    = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_enable,
    input  logic                        column_ready,
    input  logic                        position_sync,
    output logic [N_MUX-1:0]            mux_out,
    output logic [$clog2(N_MUX)-1:0]    mux_index,
    output logic [$clog2(N_SLICES)-1:0] slice_index,
    output logic                        slice_start,
    output logic                        timeout_fault
);

    localparam int MW = $clog2(N_MUX);
    localparam int SW = $clog2(N_SLICES);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [MW-1:0]    MUX_LAST   = MW'(N_MUX - 1);
    localparam logic [SW-1:0]    SLICE_LAST = SW'(N_SLICES - 1);
    localparam logic [DW-1:0]    DEAD_LAST  = DW'(DEAD_CYCLES - 1);
    localparam logic [TW-1:0]    TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [N_MUX-1:0] ONE_HOT0   = {{(N_MUX-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, DEAD, ON, FAULT} state_t;

    state_t            state_q;
    logic [N_MUX-1:0]  mux_out_q;
    logic [MW-1:0]     mux_index_q;
    logic [SW-1:0]     slice_index_q;
    logic              slice_start_q;
    logic              timeout_fault_q;
    logic              sync_pending_q;
    logic [DW-1:0]     dead_cnt_q;
    logic [TW-1:0]     to_cnt_q;

    logic              sync_now;
    logic              consume;
    logic [MW-1:0]     mux_index_d;
    logic [SW-1:0]     slice_index_d;

    // A sync seen in the same tick as column_ready counts as pending.
    always_comb begin
        sync_now      = sync_pending_q | position_sync;
        consume       = column_ready & sync_now;
        mux_index_d   = '0;
        if (!sync_now && mux_index_q != MUX_LAST) begin
            mux_index_d = mux_index_q + 1'b1;
        end
        slice_index_d = (slice_index_q == SLICE_LAST) ? '0 : slice_index_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            mux_out_q       <= '0;
            mux_index_q     <= '0;
            slice_index_q   <= SLICE_LAST;
            slice_start_q   <= 1'b0;
            timeout_fault_q <= 1'b0;
            sync_pending_q  <= 1'b0;
            dead_cnt_q      <= '0;
            to_cnt_q        <= '0;
        end else begin
            slice_start_q <= 1'b0;
            if (clk_enable) begin
                if (position_sync) begin
                    sync_pending_q <= 1'b1;
                end
                if (column_ready) begin
                    to_cnt_q <= '0;
                end
                case (state_q)
                    IDLE: begin
                        if (consume) begin
                            state_q     <= DEAD;
                            mux_index_q <= '0;
                            dead_cnt_q  <= '0;
                        end
                    end
                    DEAD: begin
                        if (column_ready) begin
                            dead_cnt_q  <= '0;
                            mux_index_q <= mux_index_d;
                        end else if (to_cnt_q == TO_LAST) begin
                            state_q         <= FAULT;
                            mux_out_q       <= '0;
                            timeout_fault_q <= 1'b1;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                            if (dead_cnt_q == DEAD_LAST) begin
                                state_q    <= ON;
                                mux_out_q  <= ONE_HOT0 << mux_index_q;
                                dead_cnt_q <= '0;
                            end else begin
                                dead_cnt_q <= dead_cnt_q + 1'b1;
                            end
                        end
                    end
                    ON: begin
                        if (column_ready) begin
                            state_q     <= DEAD;
                            mux_out_q   <= '0;
                            mux_index_q <= mux_index_d;
                            dead_cnt_q  <= '0;
                        end else if (to_cnt_q == TO_LAST) begin
                            state_q         <= FAULT;
                            mux_out_q       <= '0;
                            timeout_fault_q <= 1'b1;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    FAULT: begin
                        if (consume) begin
                            state_q         <= DEAD;
                            timeout_fault_q <= 1'b0;
                            mux_index_q     <= '0;
                            dead_cnt_q      <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
                // Every consumed sync starts the next slice, whatever the state.
                if (consume) begin
                    sync_pending_q <= 1'b0;
                    slice_index_q  <= slice_index_d;
                    slice_start_q  <= 1'b1;
                end
            end
        end
    end

    assign mux_out       = mux_out_q;
    assign mux_index     = mux_index_q;
    assign slice_index   = slice_index_q;
    assign slice_start   = slice_start_q;
    assign timeout_fault = timeout_fault_q;

endmodule
